ex3_seq_to_bin: RTL

EX3_SEQ_TO_BIN -- requirements
Module: ex3_seq_to_bin

---
 rtl/ex3_pkg.sv | 16 +
 rtl/ex3_digit_dec.sv | 25 ++
 rtl/ex3_seq_to_bin.sv | 117 +++++++++++
 3 files changed

// File: rtl/ex3_pkg.sv
// Shared types and constants for the Excess-3 sequential to binary converter.
// Optional digit validation is selected with the EX3_DIGIT_CHECK_EN macro.
package ex3_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } ex3_state_e;

  localparam int EX3_OFFSET   = 3;
  localparam int EX3_DIGIT_W  = 4;
  localparam int EX3_MIN_CODE = 3;
  localparam int EX3_MAX_CODE = 12;

endpackage

// File: rtl/ex3_digit_dec.sv
// Combinational decode of one Excess-3 code into its 4-bit value and a valid flag.
// With EX3_DIGIT_CHECK_EN defined, codes outside 3..12 are flagged and decode to 0.
module ex3_digit_dec
  import ex3_pkg::*;
(
  input  logic [EX3_DIGIT_W-1:0] i_code,
  output logic [EX3_DIGIT_W-1:0] o_val,
  output logic                   o_valid
);

  logic [EX3_DIGIT_W-1:0] w_raw;

  // Wraps modulo 16 for codes below the offset.
  assign w_raw = i_code - EX3_DIGIT_W'(EX3_OFFSET);

`ifdef EX3_DIGIT_CHECK_EN
  assign o_valid = (i_code >= EX3_DIGIT_W'(EX3_MIN_CODE)) &&
                   (i_code <= EX3_DIGIT_W'(EX3_MAX_CODE));
  assign o_val   = o_valid ? w_raw : '0;
`else
  assign o_valid = 1'b1;
  assign o_val   = w_raw;
`endif

endmodule

// File: rtl/ex3_seq_to_bin.sv
// Serial Excess-3 to binary converter: one digit per cycle, MSD first, acc = acc*10 + digit.
// Macro EX3_DIGIT_CHECK_EN enables invalid-digit detection reported on err.
module ex3_seq_to_bin
  import ex3_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int BW     = 14
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [EX3_DIGIT_W*DIGITS-1:0] E,
  output logic [BW-1:0]                 B,
  output logic                          busy,
  output logic                          done,
  output logic                          err
);

  localparam int EW = EX3_DIGIT_W * DIGITS;
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  ex3_state_e             r_state;
  ex3_state_e             w_state_nxt;
  logic [EW-1:0]          r_sr;
  logic [BW-1:0]          r_acc;
  logic [BW-1:0]          r_b;
  logic [CW-1:0]          r_cnt;
  logic [EX3_DIGIT_W-1:0] w_dig_val;
  logic                   w_dig_valid;
  logic                   w_last;
  logic [BW-1:0]          w_acc_nxt;

  ex3_digit_dec u_dec (
    .i_code  (r_sr[EW-1 -: EX3_DIGIT_W]),
    .o_val   (w_dig_val),
    .o_valid (w_dig_valid)
  );

  assign w_last    = (r_cnt == CW'(DIGITS - 1));
  // acc*10 as (acc<<3)+(acc<<1); carries above BW are dropped.
  assign w_acc_nxt = (r_acc << 3) + (r_acc << 1) + BW'(w_dig_val);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (start) w_state_nxt = CONV;
      CONV:    if (w_last) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr  <= '0;
      r_acc <= '0;
      r_b   <= '0;
      r_cnt <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_sr  <= E;
            r_acc <= '0;
            r_cnt <= '0;
          end
        end
        CONV: begin
          r_acc <= w_acc_nxt;
          r_sr  <= r_sr << EX3_DIGIT_W;
          r_cnt <= r_cnt + 1'b1;
          // Result is published on the same edge that enters DONE.
          if (w_last) r_b <= w_acc_nxt;
        end
        default: ;
      endcase
    end
  end

`ifdef EX3_DIGIT_CHECK_EN
  logic r_err_flag;
  logic r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_flag <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      if (r_state == IDLE && start) begin
        r_err_flag <= 1'b0;
      end else if (r_state == CONV) begin
        r_err_flag <= r_err_flag | ~w_dig_valid;
        if (w_last) r_err <= r_err_flag | ~w_dig_valid;
      end
    end
  end

  assign err = r_err;
`else
  logic w_unused_valid;
  assign w_unused_valid = w_dig_valid;
  assign err = 1'b0;
`endif

  assign B    = r_b;
  assign busy = (r_state != IDLE);
  assign done = (r_state == DONE);

endmodule
